counter_updown_mod: RTL and testbench
=====================================

# counter_updown_mod

Parametrised synchronous modulo counter: the next generation of the controller's 4-bit up-counter. It adds configurable width and modulus, up/down direction, count enable, parallel load, and a choice of wrap or saturate at the ends. It provides a combinational terminal-count flag and a registered wrap pulse, so it can be chained or used as a cycle/step timer in the controller.

## Interface
- WIDTH, 4: counter width in bits; legal range 1..16.
- MODULUS, 16: count range is 0..MODULUS-1; legal range 2..2^WIDTH. Illegal values are an elaboration error.
- SATURATE, 0:
  - 0: wrap at the ends.
  - 1: hold at the end value.

- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous clear, active-high; one clock; reset is asynchronous and active-high.
- en  in  1  count enable; counts one step per clock while high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- q  out  WIDTH  current count (registered).
- is_all_zero  out  1  q == 0 (combinational from q).
- tc  out  1  terminal count (combinational): q == MODULUS-1 when up=1; q == 0 when up=0.
- wrap  out  1  registered one-cycle pulse marking a wrap event.

## Operation
- Priority at each rising clk edge: clr (async) > load > en > hold.
- clr high: q = 0 and wrap = 0 immediately, without a clock. Both hold while clr is high.
- load=1: q <= load_val if load_val < MODULUS, else q <= MODULUS-1 (clamped). wrap <= 0. en and up are ignored that cycle.
- en=1, load=0, up=1:
  - q < MODULUS-1: q <= q+1, wrap <= 0.
  - q == MODULUS-1, SATURATE=0: q <= 0, wrap <= 1.
  - q == MODULUS-1, SATURATE=1: q holds, wrap <= 0.
- en=1, load=0, up=0:
  - q > 0: q <= q-1, wrap <= 0.
  - q == 0, SATURATE=0: q <= MODULUS-1, wrap <= 1.
  - q == 0, SATURATE=1: q holds, wrap <= 0.
- en=0, load=0: q holds, wrap <= 0.
- Arithmetic is WIDTH-bit unsigned. The next-state compare against MODULUS-1 is done before the increment, so no intermediate value ≥ MODULUS is ever registered.
- When MODULUS = 2^WIDTH, behaviour is identical to natural binary roll-over. With WIDTH=4, MODULUS=16, up=1, en=1 this matches the existing 4-bit counter.
- A direction change takes effect on the same edge it is sampled. tc follows up combinationally.
- No state machine beyond the count register and the wrap flop.

## Timing
- Reset values: q = 0, is_all_zero = 1, wrap = 0, tc = ~up (1 when counting down).
- Latency:
  - q: one clock from en/load/up sampled to updated q.
  - wrap: asserted in the same cycle as the wrapped q value, high for exactly one cycle per wrap event.
- tc and is_all_zero: purely combinational from q and up, with no added cycle. A chained next stage uses en_next = en & tc.
- Continuous en with SATURATE=0 produces one wrap pulse every MODULUS cycles.
- Deasserting clr: the first count occurs on the first rising edge with clr low. clr must be released synchronously to clk at the system level.
- Reset mid-count: q clears instantly. A wrap pulse in progress is cut short.

## Test plan
- Reset: WIDTH=4, MODULUS=10. Assert clr mid-count at q=7 -> q=0, wrap=0, is_all_zero=1 before the next edge. Hold clr with en=1 -> q stays 0.
- Up wrap: MODULUS=10, SATURATE=0, up=1, en=1 for 25 cycles from 0 -> q sequence 0..9,0..9,0..4. wrap high exactly on the cycles where q returns to 0 (2 pulses). tc=1 at q=9.
- Down wrap / saturate:
  - SATURATE=0, up=0 from q=2 -> 2,1,0,9,8; wrap pulses once with q=9.
  - SATURATE=1, up=0 from q=1 for 4 cycles -> 1,0,0,0; wrap never asserts.
- Load priority and clamp: load=1, en=1, load_val=6 -> q=6 next cycle. load_val=13 with MODULUS=10 -> q=9. load at q=9 with up=1 -> no wrap pulse.
- Enable and direction: en toggled 1,0,1,1 from q=3, up=1 -> 4,4,5,6. Flip up=0 at q=6 with en=1 -> 5; tc switches from (q==9) to (q==0) in the same cycle as up changes.
- Full-range regression: WIDTH=4, MODULUS=16, up=1, en=1 for 32 cycles -> 0..15,0..15. wrap pulses at each roll-over to 0. is_all_zero=1 only when q=0.

Source files
------------

// File: rtl/counter_updown_mod.sv
// counter_updown_mod
//   Parametrised modulo counter (0..MODULUS-1) with up/down direction, count
//   enable, clamped parallel load and a choice of wrap or saturate at the ends.
//
// Parameters
//   WIDTH    : counter width in bits (1..16)
//   MODULUS  : count range 0..MODULUS-1 (2..2^WIDTH)
//   SATURATE : 0 = wrap at the ends, 1 = hold at the end value
//
// Ports
//   clk         in   rising-edge clock
//   clr         in   asynchronous clear, active-high
//   en          in   count enable, one step per clock
//   up          in   direction, 1 = increment, 0 = decrement
//   load        in   synchronous parallel load (beats en)
//   load_val    in   value to load, clamped to MODULUS-1
//   q           out  current count (registered)
//   is_all_zero out  q == 0 (combinational)
//   tc          out  terminal count for the current direction (combinational)
//   wrap        out  registered one-cycle pulse on each wrap event
module counter_updown_mod #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             is_all_zero,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("counter_updown_mod: WIDTH must be in 1..16");
  end
  if (MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_modulus
    $error("counter_updown_mod: MODULUS must be in 2..2^WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_q_next;
  logic             w_wrap_next;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = (r_q == MAX_VAL);
  assign w_at_zero = (r_q == '0);

  // End-of-range is detected on the current value before stepping, so a value
  // of MODULUS or above is never formed in the register.
  always_comb begin
    w_q_next    = r_q;
    w_wrap_next = 1'b0;
    if (load) begin
      w_q_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up) begin
        if (!w_at_max) begin
          w_q_next = r_q + ONE;
        end else if (!SATURATE) begin
          w_q_next    = '0;
          w_wrap_next = 1'b1;
        end
      end else begin
        if (!w_at_zero) begin
          w_q_next = r_q - ONE;
        end else if (!SATURATE) begin
          w_q_next    = MAX_VAL;
          w_wrap_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign q           = r_q;
  assign wrap        = r_wrap;
  assign is_all_zero = w_at_zero;
  assign tc          = up ? w_at_max : w_at_zero;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod: three instances share one stimulus
// stream (modulo-10 wrapping, modulo-10 saturating, modulo-16 wrapping).
module tb_counter_updown_mod;

  logic       clk = 1'b0;
  logic       clr, en, up, load;
  logic [3:0] load_val;

  logic [3:0] q10, q10s, q16;
  logic       az10, az10s, az16;
  logic       tc10, tc10s, tc16;
  logic       wr10, wr10s, wr16;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_m10 (
    .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q10), .is_all_zero(az10), .tc(tc10), .wrap(wr10)
  );

  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_m10s (
    .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q10s), .is_all_zero(az10s), .tc(tc10s), .wrap(wr10s)
  );

  counter_updown_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_m16 (
    .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q16), .is_all_zero(az16), .tc(tc16), .wrap(wr16)
  );

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs may be changed and outputs sampled afterwards.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    step(); step();

    // Reset state
    chk("rst_q10",  q10,  0);
    chk("rst_q10s", q10s, 0);
    chk("rst_q16",  q16,  0);
    chk("rst_az10", az10, 1);
    chk("rst_wr10", wr10, 0);
    chk("rst_tc_up", tc10, 0);
    up = 1'b0; #1;
    chk("rst_tc_dn", tc10, 1);
    up = 1'b1;
    clr = 1'b0;
    #1;

    // Up count 25 cycles from 0
    en = 1'b1;
    for (int k = 0; k < 25; k++) begin
      chk("up_q10",   q10,  k % 10);
      chk("up_wr10",  wr10, (k > 0 && k % 10 == 0) ? 1 : 0);
      chk("up_tc10",  tc10, (k % 10 == 9) ? 1 : 0);
      chk("up_q10s",  q10s, (k < 9) ? k : 9);
      chk("up_wr10s", wr10s, 0);
      chk("up_q16",   q16,  k % 16);
      chk("up_wr16",  wr16, (k == 16) ? 1 : 0);
      step();
    end
    // q10 = 5 here; two more steps reach 7
    step(); step();
    chk("mid_q10", q10, 7);

    // Async clear mid-count, checked before the next edge
    clr = 1'b1; #1;
    chk("clr_q10",  q10,  0);
    chk("clr_wr10", wr10, 0);
    chk("clr_az10", az10, 1);
    chk("clr_q16",  q16,  0);
    step(); step();
    chk("clr_hold_q10", q10, 0);
    chk("clr_hold_q16", q16, 0);
    en = 1'b0;
    clr = 1'b0;
    step();
    chk("rel_idle_q10", q10, 0);

    // Load beats enable; clamp above MODULUS-1
    load = 1'b1; en = 1'b1; load_val = 4'd6;
    step();
    chk("ld6_q10", q10, 6);
    chk("ld6_wr10", wr10, 0);
    load_val = 4'd13;
    step();
    chk("ld13_q10",  q10,  9);
    chk("ld13_q10s", q10s, 9);
    chk("ld13_q16",  q16,  13);
    load_val = 4'd9;
    step();
    chk("ld_at9_q10",  q10,  9);
    chk("ld_at9_wr10", wr10, 0);
    chk("ld_at9_tc10", tc10, 1);

    // Down count from 2
    load_val = 4'd2;
    step();
    chk("ld2_q10", q10, 2);
    load = 1'b0; up = 1'b0;
    step();
    chk("dn1_q10", q10, 1); chk("dn1_q10s", q10s, 1); chk("dn1_q16", q16, 1);
    step();
    chk("dn2_q10", q10, 0); chk("dn2_q10s", q10s, 0); chk("dn2_q16", q16, 0);
    chk("dn2_tc10", tc10, 1);
    step();
    chk("dn3_q10", q10, 9); chk("dn3_wr10", wr10, 1);
    chk("dn3_q10s", q10s, 0); chk("dn3_wr10s", wr10s, 0);
    chk("dn3_q16", q16, 15); chk("dn3_wr16", wr16, 1);
    step();
    chk("dn4_q10", q10, 8); chk("dn4_wr10", wr10, 0);
    chk("dn4_q10s", q10s, 0); chk("dn4_wr10s", wr10s, 0);
    chk("dn4_q16", q16, 14);

    // Wrap pulse cut short by clear
    load = 1'b1; load_val = 4'd0;
    step();
    load = 1'b0;
    step();
    chk("cut_q10", q10, 9);
    chk("cut_wr10_pre", wr10, 1);
    clr = 1'b1; #1;
    chk("cut_wr10", wr10, 0);
    chk("cut_q10_clr", q10, 0);
    en = 1'b0;
    step();
    clr = 1'b0;

    // Enable toggling and direction change from 3
    load = 1'b1; load_val = 4'd3;
    step();
    load = 1'b0; up = 1'b1;
    en = 1'b1; step(); chk("en1_q10", q10, 4);
    en = 1'b0; step(); chk("en0_q10", q10, 4);
    chk("en0_wr10", wr10, 0);
    en = 1'b1; step(); chk("en2_q10", q10, 5);
    step();            chk("en3_q10", q10, 6);
    up = 1'b0; step(); chk("dir_q10", q10, 5);

    // tc follows up combinationally
    en = 1'b0; load = 1'b1; load_val = 4'd9;
    step();
    load = 1'b0;
    up = 1'b1; #1; chk("tc9_up", tc10, 1);
    up = 1'b0; #1; chk("tc9_dn", tc10, 0);
    load = 1'b1; load_val = 4'd0;
    step();
    load = 1'b0;
    chk("tc0_dn", tc10, 1);
    up = 1'b1; #1; chk("tc0_up", tc10, 0);

    // Full-range binary roll-over on the modulo-16 instance
    clr = 1'b1; #1;
    clr = 1'b0; up = 1'b1; en = 1'b1;
    #1;
    for (int k = 0; k < 32; k++) begin
      chk("fr_q16",  q16,  k % 16);
      chk("fr_wr16", wr16, (k == 16) ? 1 : 0);
      chk("fr_az16", az16, (k % 16 == 0) ? 1 : 0);
      chk("fr_tc16", tc16, (k % 16 == 15) ? 1 : 0);
      step();
    end
    chk("fr_end_q16",  q16,  0);
    chk("fr_end_wr16", wr16, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
